// File: rtl/line_burst_controller.sv
// line_burst_controller
//  Cache-side client of the memory arbiter CORE port. Accepts a whole-line
//  fill or writeback, runs one burst on the CORE port, packs read beats into
//  the line buffer (or feeds write beats out of it), then pulses a response.
//  Optional feature macro: BURST_CHECK_EN (sticky beat-count error flag).
module line_burst_controller #(
  parameter int DATA_WIDTH         = 32,
  parameter int CORE_ADDRESS_WIDTH = 21,
  parameter int BURST_LEN          = 8
) (
  input  logic                             i_Clk,
  input  logic                             i_Reset_n,
  input  logic                             i_Req_Valid,
  input  logic                             i_Req_Read_Write_n,
  input  logic [CORE_ADDRESS_WIDTH-1:0]    i_Req_Address,
  input  logic [DATA_WIDTH*BURST_LEN-1:0]  i_Req_Line,
  output logic                             o_Req_Ready,
  output logic                             o_Resp_Valid,
  output logic [DATA_WIDTH*BURST_LEN-1:0]  o_Resp_Line,
  output logic                             o_Burst_Error,
  output logic                             o_CORE_Valid,
  output logic                             o_CORE_Read_Write_n,
  output logic [CORE_ADDRESS_WIDTH-1:0]    o_CORE_Address,
  output logic [DATA_WIDTH-1:0]            o_CORE_Data,
  input  logic                             i_CORE_Valid,
  input  logic                             i_CORE_Data_Read,
  input  logic                             i_CORE_Last,
  input  logic [DATA_WIDTH-1:0]            i_CORE_Data
);

  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN - 1);
  // Clears the word-in-line bits so the burst always starts line aligned.
  localparam logic [CORE_ADDRESS_WIDTH-1:0] ADDR_MASK =
    {{(CORE_ADDRESS_WIDTH - CW){1'b1}}, {CW{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic                                 req_ready_q, req_ready_d;
  logic                                 core_valid_q, core_valid_d;
  logic                                 resp_valid_q, resp_valid_d;
  logic                                 rw_q, rw_d;
  logic [CORE_ADDRESS_WIDTH-1:0]        addr_q, addr_d;
  logic [BURST_LEN-1:0][DATA_WIDTH-1:0] line_q, line_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic                                 beat_s;
  logic                                 in_burst_s;

`ifdef BURST_CHECK_EN
  // Beat tally is wider than cnt and saturates one past a full line, so
  // both short and long bursts remain distinguishable from a correct one.
  localparam logic [CW+1:0] BEATS_FULL = (CW + 2)'(BURST_LEN);
  localparam logic [CW+1:0] BEATS_SAT  = (CW + 2)'(BURST_LEN + 1);
  logic [CW+1:0] beats_q, beats_d;
  logic [CW+1:0] beats_now_s;
  logic          err_q, err_d;
`endif

  // Next-state and next-output computation for the burst sequencer.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    core_valid_d = core_valid_q;
    resp_valid_d = resp_valid_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    beat_s       = 1'b0;
    in_burst_s   = 1'b0;
`ifdef BURST_CHECK_EN
    beats_d      = beats_q;
    err_d        = err_q;
    beats_now_s  = beats_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_Req_Valid) begin
          state_d      = i_Req_Read_Write_n ? S_RD : S_WR;
          req_ready_d  = 1'b0;
          core_valid_d = 1'b1;
          rw_d         = i_Req_Read_Write_n;
          addr_d       = i_Req_Address & ADDR_MASK;
          line_d       = i_Req_Line;
          cnt_d        = {CW{1'b0}};
`ifdef BURST_CHECK_EN
          beats_d      = {(CW + 2){1'b0}};
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        in_burst_s = 1'b1;
        beat_s     = i_CORE_Valid;
        if (i_CORE_Valid) begin
          line_d[cnt_q] = i_CORE_Data;
        end else begin
          line_d = line_q;
        end
      end
      S_WR: begin
        in_burst_s = 1'b1;
        beat_s     = i_CORE_Data_Read;
      end
      S_DONE: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        core_valid_d = 1'b0;
        resp_valid_d = 1'b0;
      end
    endcase

    // Shared beat accounting for both burst directions; cnt sticks on the
    // last word so excess beats overwrite or repeat it.
    if (in_burst_s) begin
      if (beat_s && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + {{(CW - 1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
`ifdef BURST_CHECK_EN
      if (beat_s && (beats_q != BEATS_SAT)) begin
        beats_now_s = beats_q + {{(CW + 1){1'b0}}, 1'b1};
      end else begin
        beats_now_s = beats_q;
      end
      beats_d = beats_now_s;
`endif
      if (i_CORE_Last) begin
        state_d      = S_DONE;
        core_valid_d = 1'b0;
        resp_valid_d = 1'b1;
`ifdef BURST_CHECK_EN
        if (beats_now_s != BEATS_FULL) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
`endif
      end else begin
        state_d = state_q;
      end
    end else begin
      in_burst_s = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      core_valid_q <= 1'b0;
      resp_valid_q <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= {CORE_ADDRESS_WIDTH{1'b0}};
      line_q       <= '0;
      cnt_q        <= {CW{1'b0}};
`ifdef BURST_CHECK_EN
      beats_q      <= {(CW + 2){1'b0}};
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      core_valid_q <= core_valid_d;
      resp_valid_q <= resp_valid_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
`ifdef BURST_CHECK_EN
      beats_q      <= beats_d;
      err_q        <= err_d;
`endif
    end
  end

  assign o_Req_Ready         = req_ready_q;
  assign o_Resp_Valid        = resp_valid_q;
  assign o_Resp_Line         = line_q;
  assign o_CORE_Valid        = core_valid_q;
  assign o_CORE_Read_Write_n = rw_q;
  assign o_CORE_Address      = addr_q;
  // Write beat is selected straight from the buffer so the arbiter sees the
  // next word in the same cycle it consumes the current one.
  assign o_CORE_Data         = line_q[cnt_q];

`ifdef BURST_CHECK_EN
  assign o_Burst_Error = err_q;
`else
  assign o_Burst_Error = 1'b0;
`endif

endmodule

// File: tb/tb_line_burst_controller.sv
// Self-checking bench for line_burst_controller: a line-level model tracks
// what the cache and arbiter should observe each cycle, plus directed
// literal checks for the fill, writeback, busy, reset and error scenarios.
module tb_line_burst_controller;

  localparam int DW = 32;
  localparam int AW = 21;
  localparam int BL = 8;
  localparam int LW = DW * BL;

`ifdef BURST_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          i_Clk = 1'b0;
  logic          i_Reset_n;
  logic          i_Req_Valid;
  logic          i_Req_Read_Write_n;
  logic [AW-1:0] i_Req_Address;
  logic [LW-1:0] i_Req_Line;
  logic          o_Req_Ready;
  logic          o_Resp_Valid;
  logic [LW-1:0] o_Resp_Line;
  logic          o_Burst_Error;
  logic          o_CORE_Valid;
  logic          o_CORE_Read_Write_n;
  logic [AW-1:0] o_CORE_Address;
  logic [DW-1:0] o_CORE_Data;
  logic          i_CORE_Valid;
  logic          i_CORE_Data_Read;
  logic          i_CORE_Last;
  logic [DW-1:0] i_CORE_Data;

  int tests = 0;
  int fails = 0;

  line_burst_controller #(.DATA_WIDTH(DW), .CORE_ADDRESS_WIDTH(AW), .BURST_LEN(BL)) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
    .i_Req_Valid(i_Req_Valid), .i_Req_Read_Write_n(i_Req_Read_Write_n),
    .i_Req_Address(i_Req_Address), .i_Req_Line(i_Req_Line),
    .o_Req_Ready(o_Req_Ready), .o_Resp_Valid(o_Resp_Valid),
    .o_Resp_Line(o_Resp_Line), .o_Burst_Error(o_Burst_Error),
    .o_CORE_Valid(o_CORE_Valid), .o_CORE_Read_Write_n(o_CORE_Read_Write_n),
    .o_CORE_Address(o_CORE_Address), .o_CORE_Data(o_CORE_Data),
    .i_CORE_Valid(i_CORE_Valid), .i_CORE_Data_Read(i_CORE_Data_Read),
    .i_CORE_Last(i_CORE_Last), .i_CORE_Data(i_CORE_Data)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- line-level model ----------------
  bit      m_busy = 1'b0;   // a burst is open on the CORE port
  bit      m_resp = 1'b0;   // response pulse due this cycle
  bit      m_rd   = 1'b0;
  bit      m_err  = 1'b0;
  int      m_addr = 0;
  int      m_idx  = 0;      // word the next beat belongs to
  int      m_beats = 0;
  int      m_line [BL];

  task automatic model_reset();
    m_busy = 1'b0; m_resp = 1'b0; m_rd = 1'b0; m_err = 1'b0;
    m_addr = 0; m_idx = 0; m_beats = 0;
    for (int k = 0; k < BL; k++) m_line[k] = 0;
  endtask

  task automatic model_step();
    bit beat;
    if (m_resp) begin
      m_resp = 1'b0;
    end else if (!m_busy) begin
      if (i_Req_Valid) begin
        m_busy  = 1'b1;
        m_rd    = i_Req_Read_Write_n;
        m_addr  = (int'(i_Req_Address) / BL) * BL;
        m_idx   = 0;
        m_beats = 0;
        for (int k = 0; k < BL; k++) m_line[k] = int'(i_Req_Line[k*DW +: DW]);
      end
    end else begin
      beat = m_rd ? i_CORE_Valid : i_CORE_Data_Read;
      if (beat) begin
        if (m_rd) m_line[m_idx] = int'(i_CORE_Data);
        if (m_idx < BL - 1) m_idx++;
        m_beats++;
      end
      if (i_CORE_Last) begin
        if (m_beats != BL && EXP_ERR) m_err = 1'b1;
        m_busy = 1'b0;
        m_resp = 1'b1;
      end
    end
  endtask

  // Compare process: advance the model on each edge, check on the falling edge.
  initial begin
    logic [LW-1:0] exp_line;
    model_reset();
    forever begin
      @(posedge i_Clk);
      if (i_Reset_n === 1'b1) model_step(); else model_reset();
      @(negedge i_Clk);
      if (i_Reset_n !== 1'b1) model_reset();
      for (int k = 0; k < BL; k++) exp_line[k*DW +: DW] = DW'(m_line[k]);
      chk("m_ready", LW'(o_Req_Ready), LW'(!m_busy && !m_resp));
      chk("m_core_valid", LW'(o_CORE_Valid), LW'(m_busy));
      chk("m_resp_valid", LW'(o_Resp_Valid), LW'(m_resp));
      chk("m_burst_err", LW'(o_Burst_Error), LW'(m_err));
      if (m_busy) begin
        chk("m_addr", LW'(o_CORE_Address), LW'(m_addr));
        chk("m_rw", LW'(o_CORE_Read_Write_n), LW'(m_rd));
        if (!m_rd) chk("m_wdata", LW'(o_CORE_Data), LW'(m_line[m_idx]));
      end
      if (m_resp) chk("m_resp_line", o_Resp_Line, exp_line);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_Req_Valid = 1'b0; i_CORE_Valid = 1'b0; i_CORE_Data_Read = 1'b0;
    i_CORE_Last = 1'b0; i_CORE_Data = '0;
  endtask

  task automatic request(input logic rw, input int addr, input int base);
    i_Req_Valid = 1'b1;
    i_Req_Read_Write_n = rw;
    i_Req_Address = AW'(addr);
    for (int k = 0; k < BL; k++) i_Req_Line[k*DW +: DW] = DW'(base + k);
    step();
    i_Req_Valid = 1'b0;
  endtask

  // n read beats carrying base+k; Last on the n-th when with_last is set.
  task automatic rd_beats(input int base, input int n, input bit with_last);
    for (int k = 0; k < n; k++) begin
      i_CORE_Valid = 1'b1;
      i_CORE_Data  = DW'(base + k);
      i_CORE_Last  = with_last && (k == n - 1);
      step();
    end
    i_CORE_Valid = 1'b0; i_CORE_Last = 1'b0;
  endtask

  task automatic check_resp_words(input string name, input int base);
    chk({name, "_resp_pulse"}, LW'(o_Resp_Valid), LW'(1));
    for (int k = 0; k < BL; k++)
      chk({name, "_word"}, LW'(o_Resp_Line[k*DW +: DW]), LW'(base + k));
  endtask

  initial begin
    i_Reset_n = 1'b0;
    i_Req_Read_Write_n = 1'b0; i_Req_Address = '0; i_Req_Line = '0;
    idle_inputs();
    step(); step();
    // 1. reset / idle
    chk("rst_ready", LW'(o_Req_Ready), LW'(1));
    chk("rst_core_valid", LW'(o_CORE_Valid), LW'(0));
    chk("rst_resp_valid", LW'(o_Resp_Valid), LW'(0));
    chk("rst_burst_err", LW'(o_Burst_Error), LW'(0));
    i_Reset_n = 1'b1;
    step(); step();

    // 2. fill from 0x00013
    request(1'b1, 32'h13, 0);
    chk("fill_addr", LW'(o_CORE_Address), LW'(32'h10));
    chk("fill_rw", LW'(o_CORE_Read_Write_n), LW'(1));
    chk("fill_valid", LW'(o_CORE_Valid), LW'(1));
    rd_beats(32'hA0, BL, 1'b1);
    check_resp_words("fill", 32'hA0);
    chk("fill_core_drop", LW'(o_CORE_Valid), LW'(0));
    step();
    chk("fill_pulse_once", LW'(o_Resp_Valid), LW'(0));
    chk("fill_ready_back", LW'(o_Req_Ready), LW'(1));

    // 3. writeback, Data_Read on non-consecutive cycles
    request(1'b0, 32'h1F, 32'hB0);
    chk("wb_rw", LW'(o_CORE_Read_Write_n), LW'(0));
    chk("wb_addr", LW'(o_CORE_Address), LW'(32'h18));
    for (int k = 0; k < BL; k++) begin
      step();
      chk("wb_data", LW'(o_CORE_Data), LW'(32'hB0 + k));
      i_CORE_Data_Read = 1'b1;
      i_CORE_Last = (k == BL - 1);
      i_CORE_Valid = 1'b1;   // ignored during a writeback
      step();
      idle_inputs();
    end
    check_resp_words("wb", 32'hB0);
    step();

    // 4. busy: second request held from mid-burst
    request(1'b1, 32'h100, 0);
    rd_beats(32'h10, 2, 1'b0);
    i_Req_Valid = 1'b1; i_Req_Read_Write_n = 1'b0; i_Req_Address = AW'(32'h20B);
    for (int k = 0; k < BL; k++) i_Req_Line[k*DW +: DW] = DW'(32'hC0 + k);
    rd_beats(32'h12, 1, 1'b0);
    chk("busy_ready", LW'(o_Req_Ready), LW'(0));
    rd_beats(32'h13, BL - 3, 1'b1);
    chk("busy_resp", LW'(o_Resp_Valid), LW'(1));
    chk("busy_ready_done", LW'(o_Req_Ready), LW'(0));
    step();
    chk("busy_ready_idle", LW'(o_Req_Ready), LW'(1));
    chk("busy_not_taken", LW'(o_CORE_Valid), LW'(0));
    step();
    i_Req_Valid = 1'b0;
    chk("busy_taken", LW'(o_CORE_Valid), LW'(1));
    chk("busy_addr", LW'(o_CORE_Address), LW'(32'h208));
    for (int k = 0; k < BL; k++) begin
      i_CORE_Data_Read = 1'b1;
      i_CORE_Last = (k == BL - 1);
      step();
    end
    idle_inputs();
    check_resp_words("busy_wb", 32'hC0);
    step();

    // 5. reset after beat 3 of a fill
    request(1'b1, 32'h40, 0);
    rd_beats(32'h50, 3, 1'b0);
    i_Reset_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_mid_valid", LW'(o_CORE_Valid), LW'(0));
    chk("rst_mid_resp", LW'(o_Resp_Valid), LW'(0));
    chk("rst_mid_ready", LW'(o_Req_Ready), LW'(1));
    step(); step();
    i_Reset_n = 1'b1;
    step();
    chk("rst_no_resp", LW'(o_Resp_Valid), LW'(0));
    request(1'b1, 32'h47, 0);
    chk("rst_refill_addr", LW'(o_CORE_Address), LW'(32'h40));
    rd_beats(32'h60, BL, 1'b1);
    check_resp_words("refill", 32'h60);
    step();

    // 6. short burst: Last on beat 6
    request(1'b1, 32'h80, 0);
    rd_beats(32'h70, 6, 1'b1);
    chk("short_resp", LW'(o_Resp_Valid), LW'(1));
    chk("short_err", LW'(o_Burst_Error), LW'(EXP_ERR));
    step();
    request(1'b1, 32'h88, 0);
    rd_beats(32'hD0, BL, 1'b1);
    check_resp_words("after_err", 32'hD0);
    chk("err_sticky", LW'(o_Burst_Error), LW'(EXP_ERR));
    step();

    // Last with no prior beat still ends the burst
    request(1'b0, 32'h90, 32'hE0);
    i_CORE_Last = 1'b1;
    step();
    idle_inputs();
    chk("bare_last_resp", LW'(o_Resp_Valid), LW'(1));
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
